// File: rtl/videogen_multi.sv
// Parametrised sync/DE timing generator with solid, scrolling LFSR noise,
// colour-bar and grey-ramp test patterns. All outputs are registered once.
module videogen_multi #(
   parameter int               H_SYNCLEN   = 62,
   parameter int               H_BACKPORCH = 60,
   parameter int               H_ACTIVE    = 720,
   parameter int               H_TOTAL     = 858,
   parameter int               V_SYNCLEN   = 6,
   parameter int               V_BACKPORCH = 30,
   parameter int               V_ACTIVE    = 480,
   parameter int               V_TOTAL     = 525,
   parameter int               CNT_W       = 11,
   parameter int               LFSR_W      = 16,
   parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hD008,
   parameter int               NOISE_SEED  = 1,
   parameter logic             SYNC_POL    = 1'b0
) (
   input  logic        clk27,
   input  logic        reset_n,
   input  logic [1:0]  mode,
   input  logic        scroll_en,
   input  logic [3:0]  scroll_step,
   input  logic [2:0]  density,
   input  logic [23:0] fg_rgb,
   input  logic [23:0] bg_rgb,
   output logic [7:0]  R_out,
   output logic [7:0]  G_out,
   output logic [7:0]  B_out,
   output logic        HSYNC_out,
   output logic        VSYNC_out,
   output logic        DE_out,
   output logic        PCLK_out,
   output logic        frame_start,
   output logic [7:0]  frame_cnt
);

   typedef enum logic [1:0] {
      MODE_SOLID = 2'd0,
      MODE_NOISE = 2'd1,
      MODE_BARS  = 2'd2,
      MODE_RAMP  = 2'd3
   } mode_t;

   localparam int X_START = H_SYNCLEN + H_BACKPORCH;
   localparam int Y_START = V_SYNCLEN + V_BACKPORCH;
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_C   = CNT_W'(H_SYNCLEN);
   localparam logic [CNT_W-1:0] V_SYNC_C   = CNT_W'(V_SYNCLEN);
   localparam logic [CNT_W-1:0] X_START_C  = CNT_W'(X_START);
   localparam logic [CNT_W-1:0] X_PRE_C    = CNT_W'(X_START - 1);
   localparam logic [CNT_W-1:0] X_END_C    = CNT_W'(X_START + H_ACTIVE);
   localparam logic [CNT_W-1:0] Y_START_C  = CNT_W'(Y_START);
   localparam logic [CNT_W-1:0] Y_END_C    = CNT_W'(Y_START + V_ACTIVE);
   localparam logic [CNT_W-1:0] BAR_LAST_C = CNT_W'(BAR_W - 1);
   localparam logic [LFSR_W-1:0] SEED      = (NOISE_SEED == 0) ? LFSR_W'(1) : LFSR_W'(NOISE_SEED);

   logic [CNT_W-1:0]  h_cnt, v_cnt, bar_px;
   logic [2:0]        bar_idx;
   mode_t             mode_q;
   logic              scroll_en_q;
   logic [3:0]        scroll_step_q;
   logic [2:0]        density_q;
   logic [LFSR_W-1:0] lfsr, frame_seed, next_seed, seed_load;

   logic        frame_origin, active, cap_pixel, noise_lit;
   logic [7:0]  noise_mask, ramp;
   logic [23:0] pix_rgb;

   assign PCLK_out     = clk27;
   assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
   assign active       = (h_cnt >= X_START_C) && (h_cnt < X_END_C) &&
                         (v_cnt >= Y_START_C) && (v_cnt < Y_END_C);
   assign cap_pixel    = (h_cnt == X_START_C) && (v_cnt == Y_START_C + CNT_W'(scroll_step_q));
   assign seed_load    = scroll_en ? next_seed : frame_seed;
   // Lit only when the top density+1 LFSR bits are all ones.
   assign noise_mask   = ~(8'hFF >> (4'(density_q) + 4'd1));
   assign noise_lit    = (lfsr[LFSR_W-1 -: 8] & noise_mask) == noise_mask;
   assign ramp         = h_cnt[7:0] - X_START_C[7:0];

   // NOTE: assign a default before the case so no path leaves pix_rgb unassigned (that would infer a latch).
   always_comb begin
      pix_rgb = bg_rgb;
      case (mode_q)
         MODE_NOISE: if (noise_lit) pix_rgb = fg_rgb;
         MODE_BARS:  pix_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
         MODE_RAMP:  pix_rgb = {3{ramp}};
         default:    pix_rgb = bg_rgb;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST_C) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + CNT_W'(1);
      end else begin
         h_cnt <= h_cnt + CNT_W'(1);
      end
   end

   // Bar counters are cleared one pixel early so they read zero at X_START.
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (h_cnt == X_PRE_C) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (bar_px == BAR_LAST_C) begin
         bar_px  <= '0;
         bar_idx <= bar_idx + 3'd1;
      end else begin
         bar_px  <= bar_px + CNT_W'(1);
      end
   end

   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         mode_q        <= MODE_SOLID;
         scroll_en_q   <= 1'b0;
         scroll_step_q <= '0;
         density_q     <= '0;
         lfsr          <= SEED;
         frame_seed    <= SEED;
         next_seed     <= SEED;
      end else if (frame_origin) begin
         mode_q        <= mode_t'(mode);
         scroll_en_q   <= scroll_en;
         scroll_step_q <= scroll_step;
         density_q     <= density;
         lfsr          <= seed_load;
         frame_seed    <= seed_load;
      end else if (mode_q == MODE_NOISE && active) begin
         if (cap_pixel) next_seed <= lfsr;
         lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
      end
   end

   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         {R_out, G_out, B_out} <= '0;
         HSYNC_out   <= SYNC_POL;
         VSYNC_out   <= SYNC_POL;
         DE_out      <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         {R_out, G_out, B_out} <= active ? pix_rgb : 24'h0;
         HSYNC_out   <= (h_cnt < H_SYNC_C) ? SYNC_POL : ~SYNC_POL;
         VSYNC_out   <= (v_cnt < V_SYNC_C) ? SYNC_POL : ~SYNC_POL;
         DE_out      <= active;
         frame_start <= frame_origin;
         if (frame_origin) frame_cnt <= frame_cnt + 8'd1;
      end
   end

   // scroll_en_q is kept as the frame's latched copy for observability.
   logic unused_ok;
   assign unused_ok = scroll_en_q;

endmodule

// File: tb/tb_videogen_multi.sv
// Self-checking bench for videogen_multi on a small raster, using a
// frame-level behavioural model of timing and patterns.
module tb_videogen_multi;

   localparam int HS = 2, HB = 1, HA = 16, HT = 20;
   localparam int VS = 1, VB = 1, VA = 8,  VT = 10;
   localparam int XS = HS + HB, YS = VS + VB;
   localparam int FRAME = HT * VT;
   localparam int BW = HA / 8;
   localparam logic [15:0] TAPS = 16'hD008;
   localparam logic [15:0] SEED = 16'h1234;
   localparam logic POL = 1'b0;

   logic        clk27 = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  mode = '0;
   logic        scroll_en = 1'b0;
   logic [3:0]  scroll_step = '0;
   logic [2:0]  density = '0;
   logic [23:0] fg_rgb = 24'hF0E0D0;
   logic [23:0] bg_rgb = 24'h102030;
   logic [7:0]  R_out, G_out, B_out, frame_cnt;
   logic        HSYNC_out, VSYNC_out, DE_out, PCLK_out, frame_start;

   always #5 clk27 = ~clk27;

   videogen_multi #(
      .H_SYNCLEN(HS), .H_BACKPORCH(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
      .V_SYNCLEN(VS), .V_BACKPORCH(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
      .CNT_W(11), .LFSR_W(16), .LFSR_TAPS(TAPS), .NOISE_SEED(32'h1234), .SYNC_POL(POL)
   ) dut (
      .clk27(clk27), .reset_n(reset_n), .mode(mode), .scroll_en(scroll_en),
      .scroll_step(scroll_step), .density(density), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
      .R_out(R_out), .G_out(G_out), .B_out(B_out), .HSYNC_out(HSYNC_out),
      .VSYNC_out(VSYNC_out), .DE_out(DE_out), .PCLK_out(PCLK_out),
      .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   int n_assert = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: frame-level picture built at each frame origin.
   int          n;
   logic [7:0]  m_fc;
   logic [15:0] m_fseed, m_nseed;
   int          m_mode, m_den, m_step;
   bit          m_bits [HA*VA];
   logic [63:0] exp_v;
   int          cur_h, cur_v;
   logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & TAPS)};
   endfunction

   function automatic bit is_lit(input logic [15:0] s, input int den);
      for (int j = 0; j <= den; j++) if (!s[15-j]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      n = 0;
      m_fc = 8'd0;
      m_fseed = SEED;
      m_nseed = SEED;
   endtask

   task automatic model_edge();
      int h, v;
      bit de;
      logic [23:0] px;
      logic [15:0] st;
      h = n % HT;
      v = (n / HT) % VT;
      if (h == 0 && v == 0) begin
         m_mode = int'(mode);
         m_den  = int'(density);
         m_step = int'(scroll_step);
         st = scroll_en ? m_nseed : m_fseed;
         m_fseed = st;
         m_fc++;
         for (int i = 0; i < HA*VA; i++) begin
            if (m_mode == 1 && i == m_step * HA) m_nseed = st;
            m_bits[i] = is_lit(st, m_den);
            if (m_mode == 1) st = lfsr_next(st);
         end
      end
      de = (h >= XS) && (h < XS + HA) && (v >= YS) && (v < YS + VA);
      px = 24'h0;
      if (de) begin
         case (m_mode)
            0: px = bg_rgb;
            1: px = m_bits[(v - YS) * HA + (h - XS)] ? fg_rgb : bg_rgb;
            2: px = bar_tab[(h - XS) / BW];
            default: px = {3{8'(h - XS)}};
         endcase
      end
      exp_v = {28'd0, (h < HS) ? POL : ~POL, (v < VS) ? POL : ~POL, de,
               (h == 0 && v == 0), m_fc, px};
      cur_h = h;
      cur_v = v;
      n++;
   endtask

   // Observation statistics and frame captures.
   int de_cnt, hs_cnt, vs_cnt, nonbg_cnt;
   int cap_sel;
   bit cap_row;
   bit cap_a [HA*VA];
   bit cap_b [HA*VA];
   logic [23:0] row_rgb [HA];

   task automatic tick();
      @(posedge clk27);
      model_edge();
      #1;
      chk("cycle", {28'd0, HSYNC_out, VSYNC_out, DE_out, frame_start, frame_cnt, R_out, G_out, B_out}, exp_v);
      if (DE_out) de_cnt++;
      if (HSYNC_out == POL) hs_cnt++;
      if (VSYNC_out == POL) vs_cnt++;
      if (DE_out && {R_out, G_out, B_out} != bg_rgb) nonbg_cnt++;
      if (DE_out && cur_h >= XS && cur_v >= YS) begin
         if (cap_sel == 1) cap_a[(cur_v - YS) * HA + cur_h - XS] = ({R_out, G_out, B_out} == fg_rgb);
         if (cap_sel == 2) cap_b[(cur_v - YS) * HA + cur_h - XS] = ({R_out, G_out, B_out} == fg_rgb);
         if (cap_row && cur_v == YS) row_rgb[cur_h - XS] = {R_out, G_out, B_out};
      end
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) tick();
   endtask

   task automatic align();
      while (n % FRAME != 0) tick();
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_rgb"}, {40'd0, R_out, G_out, B_out}, 64'd0);
      chk({tag, "_de"}, {63'd0, DE_out}, 64'd0);
      chk({tag, "_hs"}, {63'd0, HSYNC_out}, {63'd0, POL});
      chk({tag, "_vs"}, {63'd0, VSYNC_out}, {63'd0, POL});
      chk({tag, "_fs"}, {63'd0, frame_start}, 64'd0);
      chk({tag, "_fc"}, {56'd0, frame_cnt}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      int lit, diff, guard;
      cap_sel = 0;
      cap_row = 1'b0;
      model_reset();

      // Reset state, then solid background timing over two frames.
      #12;
      check_reset_state("por");
      @(negedge clk27);
      reset_n = 1'b1;
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0; nonbg_cnt = 0;
      run(2 * FRAME);
      chk("de_per_2frames", 64'(de_cnt), 64'(2 * HA * VA));
      chk("hsync_per_2frames", 64'(hs_cnt), 64'(2 * VT * HS));
      chk("vsync_per_2frames", 64'(vs_cnt), 64'(2 * HT * VS));
      chk("solid_nonbg", 64'(nonbg_cnt), 64'd0);

      // Static noise: consecutive frames identical, roughly half lit.
      mode = 2'd1; scroll_en = 1'b0; density = 3'd0; scroll_step = 4'd0;
      run(FRAME);
      cap_sel = 1; run(FRAME);
      cap_sel = 2; run(FRAME);
      cap_sel = 0;
      diff = 0; lit = 0;
      for (int i = 0; i < HA*VA; i++) begin
         if (cap_a[i] != cap_b[i]) diff++;
         if (cap_a[i]) lit++;
      end
      chk("static_noise_diff", 64'(diff), 64'd0);
      chk("lit_fraction_ok", {63'd0, (lit >= HA*VA/4) && (lit <= 3*HA*VA/4)}, 64'd1);

      // Scrolling noise: frame n+1 line k equals frame n line k+2.
      scroll_en = 1'b1; scroll_step = 4'd2;
      run(FRAME);
      cap_sel = 1; run(FRAME);
      cap_sel = 2; run(FRAME);
      cap_sel = 0;
      diff = 0;
      for (int k = 0; k < VA - 2; k++)
         for (int x = 0; x < HA; x++)
            if (cap_b[k*HA + x] != cap_a[(k+2)*HA + x]) diff++;
      chk("scroll_by_2", 64'(diff), 64'd0);
      diff = 0;
      for (int i = 0; i < HA*VA; i++) if (cap_a[i] != cap_b[i]) diff++;
      chk("scroll_moves", {63'd0, diff != 0}, 64'd1);

      // Random controls changed at random points mid-frame.
      for (int f = 0; f < 10; f++) begin
         int cut;
         cut = int'($urandom_range(1, FRAME - 1));
         run(cut);
         mode        = 2'($urandom_range(0, 3));
         scroll_en   = 1'($urandom_range(0, 1));
         scroll_step = 4'($urandom_range(0, 15));
         density     = 3'($urandom_range(0, 7));
         fg_rgb      = 24'($urandom);
         bg_rgb      = 24'($urandom);
         run(FRAME - cut);
      end

      // Mode 0 -> 2 mid-frame: current frame solid, bars from the next.
      mode = 2'd0; fg_rgb = 24'hF0E0D0; bg_rgb = 24'h102030;
      run(FRAME);
      run(5 * HT);
      mode = 2'd2;
      nonbg_cnt = 0;
      run(FRAME - 5 * HT);
      chk("no_tear_solid", 64'(nonbg_cnt), 64'd0);
      cap_row = 1'b1;
      run(FRAME);
      cap_row = 1'b0;
      chk("bar_px0_white",   64'(row_rgb[0]),      64'h FFFFFF);
      chk("bar_px1_white",   64'(row_rgb[BW-1]),   64'h FFFFFF);
      chk("bar_px2_yellow",  64'(row_rgb[BW]),     64'h FFFF00);
      chk("bar_px13_blue",   64'(row_rgb[7*BW-1]), 64'h 0000FF);
      chk("bar_px14_black",  64'(row_rgb[7*BW]),   64'h 000000);
      chk("bar_px15_black",  64'(row_rgb[HA-1]),   64'h 000000);

      // frame_cnt wraps 255 -> 0.
      guard = 0;
      while (m_fc != 8'd255 && guard < 300 * FRAME) begin
         tick();
         guard++;
      end
      chk("fc_reached_255", {56'd0, frame_cnt}, 64'd255);
      run(FRAME);
      chk("fc_wrap_0", {56'd0, frame_cnt}, 64'd0);
      chk("fc_wrap_fs", {63'd0, frame_start}, 64'd1);

      // Asynchronous reset in the middle of an active line.
      mode = 2'd1; scroll_en = 1'b1; scroll_step = 4'd3; density = 3'd1;
      align();
      run(3 * HT + 7);
      chk("pre_reset_de", {63'd0, DE_out}, 64'd1);
      #3;
      reset_n = 1'b0;
      #1;
      check_reset_state("async_rst");
      repeat (3) @(posedge clk27);
      #1;
      check_reset_state("held_rst");
      @(negedge clk27);
      reset_n = 1'b1;
      model_reset();
      tick();
      chk("first_fs_after_rst", {63'd0, frame_start}, 64'd1);
      chk("first_fc_after_rst", {56'd0, frame_cnt}, 64'd1);
      run(2 * FRAME);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
